// File: rtl/lh_pkg.sv
// Shared types and constants for the light-hash message controller.
// Holds the controller state encoding, byte-class bounds, framing markers and digest width.
package lh_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_ABSORB,
    ST_FLUSH,
    ST_LATCH,
    ST_DONE,
    ST_DISCARD
  } lh_ctrl_state_t;

  localparam logic [7:0] LH_HEAD_BYTE = 8'hFF;
  localparam logic [7:0] LH_TAIL_BYTE = 8'h00;
  localparam logic [7:0] LH_LO_BOUND  = 8'h20;
  localparam logic [7:0] LH_HI_BOUND  = 8'h7E;
  localparam int         LH_DIGEST_W  = 64;

endpackage

// File: rtl/lh_char_filter.sv
// Combinational printable-range check of one byte (zero latency, no flow control).
// Framing markers 8'hFF / 8'h00 fall outside the default bounds and are rejected here.
module lh_char_filter #(
  parameter logic [7:0] LO_BOUND = 8'h20,
  parameter logic [7:0] HI_BOUND = 8'h7E
) (
  input  logic [7:0] data,
  output logic       is_valid
);

  assign is_valid = (data >= LO_BOUND) && (data <= HI_BOUND);

endmodule

// File: rtl/lh_msg_ctrl.sv
// Frames upstream bytes into the light-hash core; digest valid 2 cycles after the last byte, one byte/cycle, in_ready low outside ABSORB/DISCARD.
// Defining LH_MSG_CTRL_LEN_CHECK_EN enforces MAX_LEN; otherwise length is unlimited and err_too_long stays 0.
module lh_msg_ctrl
  import lh_pkg::*;
#(
  parameter int         MAX_LEN  = 32,
  parameter logic [7:0] LO_BOUND = LH_LO_BOUND,
  parameter logic [7:0] HI_BOUND = LH_HI_BOUND
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             in_byte,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic                   core_init,
  output logic                   core_byte_valid,
  output logic [7:0]             core_byte,
  input  logic [LH_DIGEST_W-1:0] core_digest,
  output logic [LH_DIGEST_W-1:0] out_digest,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   err_invalid_byte,
  output logic                   err_too_long
);

  lh_ctrl_state_t state, next_state;
  logic accept;
  logic byte_ok;
  logic at_max;
  logic wr_byte;
  logic set_err_invalid;
  logic set_err_long;

  lh_char_filter #(
    .LO_BOUND (LO_BOUND),
    .HI_BOUND (HI_BOUND)
  ) u_filter (
    .data     (in_byte),
    .is_valid (byte_ok)
  );

  assign accept = in_valid && in_ready;

`ifdef LH_MSG_CTRL_LEN_CHECK_EN
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);

  logic [LEN_W-1:0] len_cnt;

  assign at_max = (len_cnt == MAX_CNT);

  // Saturates at MAX_CNT because writes are blocked once at_max is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_cnt      <= '0;
      err_too_long <= 1'b0;
    end else begin
      err_too_long <= set_err_long;
      if (state == ST_INIT)
        len_cnt <= '0;
      else if (wr_byte)
        len_cnt <= len_cnt + 1'b1;
    end
  end
`else
  logic unused_max_len;

  assign at_max         = 1'b0;
  assign err_too_long   = 1'b0;
  assign unused_max_len = ^MAX_LEN ^ set_err_long;
`endif

  always_comb begin
    next_state      = state;
    wr_byte         = 1'b0;
    set_err_invalid = 1'b0;
    set_err_long    = 1'b0;
    case (state)
      ST_IDLE:    if (in_valid) next_state = ST_INIT;
      ST_INIT:    next_state = ST_ABSORB;
      ST_ABSORB: begin
        if (accept) begin
          if (!byte_ok) begin
            set_err_invalid = 1'b1;
            next_state      = in_last ? ST_IDLE : ST_DISCARD;
          end else if (at_max) begin
            set_err_long = 1'b1;
            next_state   = in_last ? ST_IDLE : ST_DISCARD;
          end else begin
            wr_byte = 1'b1;
            if (in_last) next_state = ST_FLUSH;
          end
        end
      end
      ST_FLUSH:   next_state = ST_LATCH;
      ST_LATCH:   next_state = ST_DONE;
      ST_DONE:    if (out_ready) next_state = ST_IDLE;
      ST_DISCARD: if (accept && in_last) next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // Flag outputs are registered from next_state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      in_ready         <= 1'b0;
      core_init        <= 1'b0;
      core_byte_valid  <= 1'b0;
      core_byte        <= 8'h00;
      out_digest       <= '0;
      out_valid        <= 1'b0;
      err_invalid_byte <= 1'b0;
    end else begin
      state            <= next_state;
      in_ready         <= (next_state == ST_ABSORB) || (next_state == ST_DISCARD);
      core_init        <= (next_state == ST_INIT);
      core_byte_valid  <= wr_byte;
      err_invalid_byte <= set_err_invalid;
      if (wr_byte)
        core_byte <= in_byte;
      if (state == ST_LATCH) begin
        out_digest <= core_digest;
        out_valid  <= 1'b1;
      end else if (state == ST_DONE && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lh_msg_ctrl.sv
// Directed bench for lh_msg_ctrl with a behavioural hash core and a digest scoreboard.
// Expectations for the long message follow LH_MSG_CTRL_LEN_CHECK_EN.
module tb_lh_msg_ctrl;

  localparam logic [63:0] IV = 64'hCBF2_9CE4_8422_2325;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        core_init;
  logic        core_byte_valid;
  logic [7:0]  core_byte;
  logic [63:0] core_digest = 64'h0;
  logic [63:0] out_digest;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        err_invalid_byte;
  logic        err_too_long;

  int n_checks = 0;
  int n_pass   = 0;
  int n_init = 0, n_wr = 0, n_einv = 0, n_elong = 0, n_out = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  lh_msg_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_byte          (in_byte),
    .in_valid         (in_valid),
    .in_last          (in_last),
    .in_ready         (in_ready),
    .core_init        (core_init),
    .core_byte_valid  (core_byte_valid),
    .core_byte        (core_byte),
    .core_digest      (core_digest),
    .out_digest       (out_digest),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .err_invalid_byte (err_invalid_byte),
    .err_too_long     (err_too_long)
  );

  function automatic logic [63:0] mix(input logic [63:0] d, input logic [7:0] b);
    return (d ^ {56'd0, b}) * 64'h0000_0100_0000_01B3;
  endfunction

  function automatic logic [63:0] model(input logic [7:0] m[$]);
    logic [63:0] d = IV;
    foreach (m[i]) d = mix(d, m[i]);
    return d;
  endfunction

  // Behavioural core: digest reflects each absorbed byte one cycle after the absorption edge.
  always @(posedge clk) begin
    if (core_init)            core_digest <= IV;
    else if (core_byte_valid) core_digest <= mix(core_digest, core_byte);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  always @(negedge clk) begin
    logic [63:0] e;
    if (core_init)        n_init++;
    if (core_byte_valid)  n_wr++;
    if (err_invalid_byte) n_einv++;
    if (err_too_long)     n_elong++;
    if (out_valid && out_ready) begin
      n_out++;
      check("sb_nonempty", {63'd0, exp_q.size() != 0}, 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("digest", out_digest, e);
      end
    end
  end

  task automatic drive_byte(input logic [7:0] b, input logic last);
    int t = 0;
    in_byte  = b;
    in_valid = 1'b1;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send(input logic [7:0] m[$], input bit good);
    if (good) exp_q.push_back(model(m));
    for (int i = 0; i < m.size(); i++) drive_byte(m[i], i == m.size() - 1);
  endtask

  task automatic wait_drain(input string tag);
    int t = 0;
    while (exp_q.size() != 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    check(tag, exp_q.size(), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [7:0] msg[$];
    int b_init, b_wr, b_einv, b_elong, b_out;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_flags", {50'd0, in_ready, core_init, core_byte_valid, out_valid,
                          err_invalid_byte, err_too_long, core_byte}, 64'd0);
    check("reset_digest", out_digest, 64'd0);

    // "abc" with timing of out_valid
    b_init = n_init; b_wr = n_wr; b_out = n_out;
    msg = '{8'h61, 8'h62, 8'h63};
    send(msg, 1'b1);
    @(negedge clk);
    check("abc_flush", {62'd0, out_valid, core_byte_valid}, 64'd1);
    @(negedge clk);
    check("abc_latch", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    check("abc_valid", {63'd0, out_valid}, 64'd1);
    wait_drain("abc_drain");
    check("abc_init", n_init - b_init, 64'd1);
    check("abc_writes", n_wr - b_wr, 64'd3);
    check("abc_outs", n_out - b_out, 64'd1);

    // invalid byte mid-message: dropped whole
    b_wr = n_wr; b_einv = n_einv; b_out = n_out;
    msg = '{8'h61, 8'h7F, 8'h62};
    send(msg, 1'b0);
    repeat (4) @(negedge clk);
    check("inv_err", n_einv - b_einv, 64'd1);
    check("inv_writes", n_wr - b_wr, 64'd1);
    check("inv_no_digest", n_out - b_out, 64'd0);
    msg = '{8'h4F, 8'h4B};
    send(msg, 1'b1);
    wait_drain("after_inv_drain");

    // 33-byte message
    b_wr = n_wr; b_elong = n_elong; b_out = n_out;
    msg = {};
    for (int i = 0; i < 33; i++) msg.push_back(8'h41);
`ifdef LH_MSG_CTRL_LEN_CHECK_EN
    send(msg, 1'b0);
    repeat (4) @(negedge clk);
    check("long_writes", n_wr - b_wr, 64'd32);
    check("long_err", n_elong - b_elong, 64'd1);
    check("long_outs", n_out - b_out, 64'd0);
`else
    send(msg, 1'b1);
    wait_drain("long_drain");
    check("long_writes", n_wr - b_wr, 64'd33);
    check("long_err", n_elong - b_elong, 64'd0);
    check("long_outs", n_out - b_out, 64'd1);
`endif

    // digest stalled by out_ready=0 while upstream keeps offering
    out_ready = 1'b0;
    msg = '{8'h68, 8'h69};
    send(msg, 1'b1);
    begin
      int t = 0;
      while (!out_valid && t < 20) begin
        @(negedge clk);
        t++;
      end
    end
    check("stall_valid", {63'd0, out_valid}, 64'd1);
    in_byte = 8'h55; in_valid = 1'b1; in_last = 1'b0;
    b_wr = n_wr; b_init = n_init;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_ctrl", {61'd0, in_ready, out_valid, core_byte_valid}, 64'd2);
      check("stall_digest", out_digest, model(msg));
    end
    check("stall_core", (n_wr - b_wr) + (n_init - b_init), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain("stall_drain");

    // asynchronous reset inside ABSORB
    b_out = n_out;
    drive_byte(8'h31, 1'b0);
    drive_byte(8'h32, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_flags", {50'd0, in_ready, core_init, core_byte_valid, out_valid,
                         err_invalid_byte, err_too_long, core_byte}, 64'd0);
    check("arst_digest", out_digest, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("arst_no_digest", n_out - b_out, 64'd0);
    msg = '{8'h78};
    send(msg, 1'b1);
    wait_drain("arst_x_drain");

    // single-byte bounds
    b_out = n_out; b_einv = n_einv;
    msg = '{8'h20};
    send(msg, 1'b1);
    wait_drain("lo_bound_drain");
    msg = '{8'h7E};
    send(msg, 1'b1);
    wait_drain("hi_bound_drain");
    msg = '{8'h1F};
    send(msg, 1'b0);
    repeat (4) @(negedge clk);
    check("bounds_outs", n_out - b_out, 64'd2);
    check("bounds_err", n_einv - b_einv, 64'd1);
    check("sb_empty_end", exp_q.size(), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lh_msg_ctrl.md
# lh_msg_ctrl

Message-framing controller placed in front of the light-hash core: accepts an upstream byte stream with valid/ready/last handshake, filters bytes to printable ASCII, enforces a maximum message length, sequences the core (init pulse, one data byte per cycle, flush) and returns the 64-bit digest on a valid/ready output port. Errored messages are dropped whole and never produce a digest.

## Interface
- MAX_LEN, 32, maximum accepted message length in bytes (1..255)
- LO_BOUND, 8'h20, lowest valid byte (space)
- HI_BOUND, 8'h7E, highest valid byte (tilde)
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- in_byte  input  8  upstream message byte
- in_valid  input  1  in_byte valid
- in_last  input  1  in_byte is final byte of message
- in_ready  output  1  controller accepts in_byte this cycle
- core_init  output  1  one-cycle pulse: core clears digest state
- core_byte_valid  output  1  core absorbs core_byte at next edge
- core_byte  output  8  byte to core
- core_digest  input  64  core digest; reflects every absorbed byte one cycle after absorption edge
- out_digest  output  64  latched digest
- out_valid  output  1  out_digest valid
- out_ready  input  1  downstream takes digest
- err_invalid_byte  output  1  one-cycle pulse: byte outside LO_BOUND..HI_BOUND
- err_too_long  output  1  one-cycle pulse: message exceeded MAX_LEN

## Operation
- Reset: all outputs 0, out_digest 64'h0, state IDLE, length counter 0. Reset mid-message abandons it; no digest, no error pulse.
- All outputs registered. Handshake on in_* and out_* : transfer when valid && ready at posedge.
- States: IDLE, INIT, ABSORB, FLUSH, LATCH, DONE, DISCARD.
- IDLE: in_ready=0. in_valid -> INIT (byte not consumed).
- INIT: core_init=1 one cycle, counter cleared -> ABSORB.
- ABSORB: in_ready=1. Per accepted byte:
  - in range: core_byte<=in_byte, core_byte_valid<=1 next cycle, counter+1; with in_last -> FLUSH, else stay.
  - out of range (incl. 8'hFF head / 8'h00 tail markers): err_invalid_byte pulse, no core write; in_last -> IDLE, else DISCARD.
  - in range but counter already MAX_LEN: err_too_long pulse, no core write; in_last -> IDLE, else DISCARD.
  - no accepted byte: core_byte_valid<=0.
- FLUSH: core absorbs last byte; in_ready=0 -> LATCH.
- LATCH: out_digest<=core_digest, out_valid<=1 -> DONE.
- DONE: hold out_valid/out_digest; out_ready -> out_valid<=0, IDLE. in_ready=0 throughout.
- DISCARD: in_ready=1, bytes dropped silently (no further error pulses); accepted in_last -> IDLE.
- Counter width $clog2(MAX_LEN+1); never wraps.

## Timing
- Byte accepted at edge e: core_byte_valid high during cycle after e.
- Last byte accepted at edge e0: FLUSH e0..e1, LATCH e1..e2, out_valid high from e2. Latency last-byte to out_valid: 2 cycles.
- Throughput in ABSORB: one byte/cycle, no bubbles.
- Message start overhead: in_valid in IDLE -> in_ready high 2 cycles later.
- Digest handshake at edge d -> IDLE; new message in_ready earliest d+2 edges.
- Error pulses coincide with core_byte_valid cycle slot (cycle after offending acceptance).

## Configuration
- LH_MSG_CTRL_LEN_CHECK_EN defined: MAX_LEN enforced as above.
- Not defined: no counter, unlimited length, err_too_long tied 0; MAX_LEN unused.

## Structure
- Package lh_pkg: state enum lh_ctrl_state_t, LH_HEAD_BYTE 8'hFF, LH_TAIL_BYTE 8'h00, LH_LO_BOUND 8'h20, LH_HI_BOUND 8'h7E, LH_DIGEST_W 64.
- Sub-module lh_char_filter: combinational range check of in_byte against LO_BOUND/HI_BOUND, parameterised.

## Test plan
- "abc" (61,62,63, last on 63), out_ready=1 -> 1 core_init, 3 core_byte_valid cycles, out_valid 2 cycles after 63 accepted, out_digest = core_digest model.
- "a",8'h7F,"b"(last) -> err_invalid_byte one pulse, "b" dropped, no out_valid, next message hashes correctly.
- 33 bytes 8'h41 (last on 33rd), LEN_CHECK_EN -> 32 core writes, err_too_long pulse on 33rd, no digest; macro off -> 33 writes, digest produced.
- Digest pending with out_ready=0 for 10 cycles while in_valid=1 -> out_digest stable, in_ready=0, no core activity.
- rst_n low during ABSORB after 2 bytes -> all outputs 0 immediately, IDLE, following "x" message yields single-byte digest.
- Single-byte message 8'h20 and 8'h7E (bounds) -> accepted, digest produced; 8'h1F -> rejected.
